// File: rtl/eth_rx_dest_filter.sv
// Receive-side destination-MAC filter: buffers the 6-byte destination address, replays it for
// accepted frames and bypasses the rest of the frame; rejected and runt frames are swallowed.
module eth_rx_dest_filter #(
   parameter bit          ACCEPT_BROADCAST = 1'b1,
   parameter bit          ACCEPT_MULTICAST = 1'b0,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [47:0]          local_mac,
   input  logic                 promisc_en,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   output logic [CNT_WIDTH-1:0] pass_count,
   output logic [CNT_WIDTH-1:0] drop_count
);

   typedef enum logic [1:0] {StHdr, StReplay, StPass, StDrop} state_e;

   state_e               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [2:0]           ridx_q, ridx_d;
   logic [47:0]          hdr_q;
   logic [CNT_WIDTH-1:0] pass_q, drop_q;
   logic                 hdr_wr, pass_inc, drop_inc;
   logic [47:0]          dest;
   logic                 match;
   logic [7:0]           replay_byte;

   // The 6th byte is still on the bus when the decision is made.
   assign dest  = {hdr_q[47:8], s_axis_tdata};
   assign match = promisc_en | (dest == local_mac)
                | (ACCEPT_BROADCAST & (dest == 48'hFFFF_FFFF_FFFF))
                | (ACCEPT_MULTICAST & dest[40]);

   always_comb begin
      case (ridx_q)
         3'd0:    replay_byte = hdr_q[47:40];
         3'd1:    replay_byte = hdr_q[39:32];
         3'd2:    replay_byte = hdr_q[31:24];
         3'd3:    replay_byte = hdr_q[23:16];
         3'd4:    replay_byte = hdr_q[15:8];
         default: replay_byte = hdr_q[7:0];
      endcase
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      ridx_d        = ridx_q;
      hdr_wr        = 1'b0;
      pass_inc      = 1'b0;
      drop_inc      = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = replay_byte;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      case (state_q)
         StHdr: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               hdr_wr = 1'b1;
               if (s_axis_tlast) begin
                  drop_inc = 1'b1;
                  idx_d    = 3'd0;
               end else if (idx_q == 3'd5) begin
                  idx_d   = 3'd0;
                  ridx_d  = 3'd0;
                  state_d = match ? StReplay : StDrop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StReplay: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) begin
               if (ridx_q == 3'd5) begin
                  ridx_d  = 3'd0;
                  state_d = StPass;
               end else begin
                  ridx_d = ridx_q + 3'd1;
               end
            end
         end
         StPass: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
            s_axis_tready = m_axis_tready;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
               pass_inc = 1'b1;
               idx_d    = 3'd0;
               state_d  = StHdr;
            end
         end
         StDrop: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_inc = 1'b1;
               state_d  = StHdr;
            end
         end
         default: state_d = StHdr;
      endcase
      // Handshakes are held off for the whole reset cycle.
      if (!rst_n) begin
         s_axis_tready = 1'b0;
         m_axis_tvalid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StHdr;
         idx_q   <= 3'd0;
         ridx_q  <= 3'd0;
         hdr_q   <= 48'h0;
         pass_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ridx_q  <= ridx_d;
         if (hdr_wr) begin
            case (idx_q)
               3'd0:    hdr_q[47:40] <= s_axis_tdata;
               3'd1:    hdr_q[39:32] <= s_axis_tdata;
               3'd2:    hdr_q[31:24] <= s_axis_tdata;
               3'd3:    hdr_q[23:16] <= s_axis_tdata;
               3'd4:    hdr_q[15:8]  <= s_axis_tdata;
               default: hdr_q[7:0]   <= s_axis_tdata;
            endcase
         end
         if (pass_inc && (pass_q != {CNT_WIDTH{1'b1}})) pass_q <= pass_q + CNT_WIDTH'(1);
         if (drop_inc && (drop_q != {CNT_WIDTH{1'b1}})) drop_q <= drop_q + CNT_WIDTH'(1);
      end
   end

   assign pass_count = pass_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_eth_rx_dest_filter.sv
// Bench for eth_rx_dest_filter: two builds (default, and broadcast-off with 2-bit counters)
// driven from a shared frame driver; table of frames plus a mid-frame reset sequence.
module tb_eth_rx_dest_filter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [47:0] local_mac;
   logic        promisc_en;
   logic [7:0]  tdata;
   logic        tvalid, tlast, tuser;
   logic        sel;
   logic        m_ready;
   logic        rnd_ready;

   logic        ready_a, mvalid_a, mlast_a, muser_a;
   logic        ready_b, mvalid_b, mlast_b, muser_b;
   logic [7:0]  mdata_a, mdata_b;
   logic [15:0] pass_a, drop_a;
   logic [1:0]  pass_b, drop_b;

   logic        s_ready, m_valid, m_last, m_user;
   logic [7:0]  m_data;

   always #5 clk = ~clk;

   assign s_ready = sel ? ready_b  : ready_a;
   assign m_valid = sel ? mvalid_b : mvalid_a;
   assign m_last  = sel ? mlast_b  : mlast_a;
   assign m_user  = sel ? muser_b  : muser_a;
   assign m_data  = sel ? mdata_b  : mdata_a;

   eth_rx_dest_filter #(
      .ACCEPT_BROADCAST(1'b1), .ACCEPT_MULTICAST(1'b0), .CNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .promisc_en(promisc_en),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(ready_a),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .m_axis_tdata(mdata_a), .m_axis_tvalid(mvalid_a), .m_axis_tready(m_ready),
      .m_axis_tlast(mlast_a), .m_axis_tuser(muser_a),
      .pass_count(pass_a), .drop_count(drop_a)
   );

   eth_rx_dest_filter #(
      .ACCEPT_BROADCAST(1'b0), .ACCEPT_MULTICAST(1'b0), .CNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .promisc_en(promisc_en),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel), .s_axis_tready(ready_b),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .m_axis_tdata(mdata_b), .m_axis_tvalid(mvalid_b), .m_axis_tready(m_ready),
      .m_axis_tlast(mlast_b), .m_axis_tuser(muser_b),
      .pass_count(pass_b), .drop_count(drop_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   logic [7:0] got_q[$];
   int         valid_cycles, tuser_bad, last_seen, stalls;
   logic       last_tuser;

   always @(negedge clk) begin
      if (m_valid) valid_cycles++;
      if (m_valid && m_ready) begin
         got_q.push_back(m_data);
         if (m_user && !m_last) tuser_bad++;
         if (m_last) begin
            last_seen++;
            last_tuser = m_user;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
      bit ok;
      ok     = 1'b0;
      tdata  = d;
      tlast  = last;
      tuser  = user;
      tvalid = 1'b1;
      for (int g = 0; g < 200; g++) begin
         @(negedge clk);
         ok = s_ready;
         if (!ok) stalls++;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL handshake_timeout: got tready=0, expected tready=1 within 200 cycles");
      end
   endtask

   typedef struct {
      logic [47:0] dest;
      int          len;
      bit          promisc;
      bit          user;
      bit          rnd;
      bit          gaps;
      bit          sel;
      bit          exp_pass;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] frame[$];
   int         ep_a, ed_a, ep_b, ed_b;

   task automatic run_vec(input int id, input vec_t v);
      int errs;
      sel          = v.sel;
      promisc_en   = v.promisc;
      rnd_ready    = v.rnd;
      got_q.delete();
      valid_cycles = 0;
      tuser_bad    = 0;
      last_seen    = 0;
      stalls       = 0;
      last_tuser   = 1'b0;
      frame.delete();
      for (int i = 0; i < v.len; i++) begin
         if (i < 6) frame.push_back(8'(v.dest >> (8 * (5 - i))));
         else frame.push_back(8'(i * 7 + v.len));
      end
      for (int i = 0; i < v.len; i++) begin
         if (v.gaps && (i % 3 == 2)) begin
            tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         send_byte(frame[i], i == v.len - 1, v.user && (i == v.len - 1));
      end
      tvalid = 1'b0;
      if (v.sel) begin
         if (v.exp_pass) ep_b = (ep_b < 3) ? ep_b + 1 : 3;
         else ed_b = (ed_b < 3) ? ed_b + 1 : 3;
      end else begin
         if (v.exp_pass) ep_a = (ep_a < 65535) ? ep_a + 1 : 65535;
         else ed_a = (ed_a < 65535) ? ed_a + 1 : 65535;
      end
      if (v.exp_pass) begin
         check($sformatf("v%0d_out_len", id), got_q.size(), v.len);
         errs = 0;
         for (int i = 0; i < v.len && i < got_q.size(); i++) if (got_q[i] !== frame[i]) errs++;
         check($sformatf("v%0d_out_bytes_bad", id), errs, 0);
         check($sformatf("v%0d_tlast_count", id), last_seen, 1);
         check($sformatf("v%0d_tuser_on_last", id), last_tuser, v.user);
         check($sformatf("v%0d_tuser_not_last", id), tuser_bad, 0);
      end else begin
         check($sformatf("v%0d_mvalid_cycles", id), valid_cycles, 0);
         check($sformatf("v%0d_in_stalls", id), stalls, 0);
      end
      if (v.sel) begin
         check($sformatf("v%0d_pass_count_b", id), pass_b, ep_b);
         check($sformatf("v%0d_drop_count_b", id), drop_b, ed_b);
      end else begin
         check($sformatf("v%0d_pass_count_a", id), pass_a, ep_a);
         check($sformatf("v%0d_drop_count_a", id), drop_a, ed_a);
      end
   endtask

   localparam logic [47:0] Mac   = 48'h0200_0000_0001;
   localparam logic [47:0] Miss  = 48'h0200_0000_0099;
   localparam logic [47:0] Bcast = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] Mcast = 48'h0100_5E00_0001;

   initial begin
      rst_n = 1'b0; local_mac = Mac; promisc_en = 1'b0; rnd_ready = 1'b0;
      tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; sel = 1'b0; m_ready = 1'b1;
      ep_a = 0; ed_a = 0; ep_b = 0; ed_b = 0;

      //           dest   len  prm   usr   rnd   gap   sel   pass
      vecs.push_back('{Mac,   64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{Bcast, 64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{Miss, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{Miss, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{Mac,    4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{Mac,   64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{Mac,   70, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{Mcast, 64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{Mac,    6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{Mac,    7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{Bcast, 64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{Mac,   20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      for (int k = 0; k < 4; k++) vecs.push_back('{Miss, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", ready_a, 1'b0);
      check("rst_m_tvalid", mvalid_a, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_s_tready", ready_a, 1'b1);
      check("idle_pass_a", pass_a, 0);
      check("idle_drop_a", drop_a, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Mid-PASS reset: 10 bytes into a matching frame, hold byte 11 valid through reset.
      sel = 1'b0; promisc_en = 1'b0; rnd_ready = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'(Mac >> (8 * (5 - (i % 6)))), 1'b0, 1'b0);
      tdata = 8'hA5; tvalid = 1'b1; tlast = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("midrst_m_tvalid", mvalid_a, 1'b0);
      check("midrst_s_tready", ready_a, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1; tvalid = 1'b0;
      @(negedge clk);
      check("postrst_m_tvalid", mvalid_a, 1'b0);
      check("postrst_pass_a", pass_a, 0);
      check("postrst_drop_a", drop_a, 0);
      check("postrst_drop_b", drop_b, 0);
      @(posedge clk);
      #1;
      ep_a = 0; ed_a = 0; ep_b = 0; ed_b = 0;
      run_vec(100, '{Mac,  64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      run_vec(101, '{Miss, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
